input_debounce_events: RTL and testbench
========================================

# input_debounce_events

Multi-channel input conditioner, the parametrised successor to the team's switch debouncer. Each channel is synchronised, debounced against a shared 1 ms timebase, and decoded into single-cycle rise and fall event pulses. An optional long-press detector flags channels held high for a configurable time. The block sits between raw board switches/buttons and the lab control FSMs, which consume either levels or events.

## Interface
- `clk_freq`: default 100_000_000. System clock in Hz. Must be a multiple of 1000 and at least 1000.
- `stable_time`: default 10. Debounce window in ms. Must be at least 1.
- `input_count`: default 16. Number of channels, 1..32.
- `sync_stages`: default 2. Synchroniser depth, 2..4.
- `long_press_time`: default 1000. Long-press threshold in ms. Must exceed `stable_time`.

- `clk`  in  1  system clock, all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `switch_inputs`  in  `input_count`  raw, asynchronous inputs.
- `switch_outputs`  out  `input_count`  debounced levels.
- `rise_pulse`  out  `input_count`  one-cycle pulse when the debounced level goes 0→1.
- `fall_pulse`  out  `input_count`  one-cycle pulse when the debounced level goes 1→0.
- `long_press`  out  `input_count`  one-cycle pulse at the long-press threshold.
- `long_held`  out  `input_count`  level, high from the long-press threshold until the fall.
- `any_event`  out  1  OR of all bits of `rise_pulse` and `fall_pulse`.

## Operation
- **Synchroniser.** A `sync_stages`-deep flop chain per channel. The last stage is `s[i]`.
- **Prescaler.**
  - A shared counter runs 0..`clk_freq/1000`-1.
  - `tick` is high for one cycle when the counter equals its terminal value, then the counter wraps to 0.
- **Debounce counter.** Per channel, width `$clog2(stable_time+1)`.
  - If `s[i] == switch_outputs[i]`: count clears to 0 every cycle. This holds regardless of `tick`.
  - Else, on `tick`: count increments.
  - When the mismatch persists and count is `stable_time-1` on a `tick`, the channel accepts the new value on that edge:
    - `switch_outputs[i]` is set to `s[i]`.
    - count clears to 0.
    - The matching rise or fall pulse is registered high for exactly one cycle.
  - Any mismatch that ends before acceptance leaves `switch_outputs[i]` unchanged and generates no pulse.
- **Long press** (only when the macro in Configuration is defined). Per-channel tick counter, width `$clog2(long_press_time+1)`.
  - While `switch_outputs[i]` is 1: increment on `tick`, saturating at `long_press_time`.
  - On the edge where the counter reaches `long_press_time`: `long_press[i]` pulses for one cycle and `long_held[i]` sets.
  - When `switch_outputs[i]` is 0: the counter and `long_held[i]` clear in the same cycle that `fall_pulse[i]` is high.
- **Independence.** Channels are independent. Simultaneous acceptances on several channels each produce their own pulse in the same cycle.
- **Reset.**
  - While `reset` is high, every flop clears to 0: synchronisers, prescaler, counters and all outputs.
  - Reset asserted mid-operation aborts any pending debounce or long-press count immediately.
  - After release, a channel whose input is held high is accepted after the normal window, with one `rise_pulse`.

## Timing
- **Debounce latency.** From an input change to `switch_outputs` updating:
  - `sync_stages` cycles, plus
  - between (`stable_time`-1)·`clk_freq/1000`+1 and `stable_time`·`clk_freq/1000` cycles, set by tick alignment.
- **Pulses.**
  - `rise_pulse` / `fall_pulse` are asserted in the same cycle that `switch_outputs` first shows the new value. Width is exactly 1 cycle.
  - `any_event` is combinational from the registered pulses, so it is coincident with them.
- **Long-press latency.**
  - `long_press` asserts `long_press_time` ticks after the rise acceptance.
  - Tick-aligned, this is exactly `long_press_time`·`clk_freq/1000` cycles after `rise_pulse`.
  - `long_held` goes high in the same cycle as `long_press`.
- **Outputs.** All outputs except `any_event` are registered. All reset to 0.

## Configuration
- `DEBOUNCE_LONG_PRESS_EN` defined:
  - The long-press counters and logic are compiled in.
  - `long_press` and `long_held` behave as described in Operation.
- `DEBOUNCE_LONG_PRESS_EN` undefined:
  - No long-press counters are synthesised.
  - `long_press` and `long_held` are tied to constant 0.
  - All other behaviour is identical.

## Test plan
Bench parameters: `clk_freq`=10_000 (tick every 10 cycles), `stable_time`=3, `input_count`=4, `sync_stages`=2, `long_press_time`=20, macro defined.

- **Reset.** Assert `reset` with all inputs at 0xF, then release → every output reads 0 throughout reset. Exactly one `rise_pulse`=0xF occurs 21–32 cycles after release, then `switch_outputs`=0xF.
- **Glitch rejection.** Channel 0 is 1-cycle pulsed and, separately, held high for 15 cycles → `switch_outputs[0]` stays 0 and no pulses appear.
- **Clean press/release.** Channel 1 held high for 100 cycles, then low → `rise_pulse[1]` once and `fall_pulse[1]` once, each 1 cycle wide, each with latency in 23..32 cycles. `any_event` is coincident with both.
- **Simultaneous channels.** Channels 2 and 3 toggle on the same cycle → `rise_pulse`=0xC in a single cycle.
- **Long press.** Channel 0 held high for 300 cycles → `long_press[0]` pulses exactly 200 cycles after `rise_pulse[0]`. `long_held[0]` stays high until the cycle of `fall_pulse[0]`. Rebuild with the macro undefined → both long-press outputs stay 0.
- **Reset mid-count.** Assert `reset` during a pending 0→1 window on channel 1 → the count aborts, with no pulse during or immediately after reset. After release, normal acceptance timing restarts from 0.

Source files
------------

// File: rtl/input_debounce_events.sv
// Multi-channel switch conditioner: synchroniser, debounce on a shared 1 ms tick, rise/fall event pulses.
// Optional long-press detector compiled in when DEBOUNCE_LONG_PRESS_EN is defined.
module input_debounce_events #(
    parameter int clk_freq        = 100_000_000,
    parameter int stable_time     = 10,
    parameter int input_count     = 16,
    parameter int sync_stages     = 2,
    parameter int long_press_time = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [input_count-1:0] switch_inputs,
    output logic [input_count-1:0] switch_outputs,
    output logic [input_count-1:0] rise_pulse,
    output logic [input_count-1:0] fall_pulse,
    output logic [input_count-1:0] long_press,
    output logic [input_count-1:0] long_held,
    output logic                   any_event
);

    localparam int DIV = clk_freq / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(stable_time + 1);

    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic [input_count-1:0] sync_q [sync_stages];
    logic [input_count-1:0] s;
    logic [DW-1:0]          db_cnt [input_count];
    logic [input_count-1:0] accept;
    logic [input_count-1:0] out_next;

    assign tick = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < sync_stages; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= switch_inputs;
            for (int k = 1; k < sync_stages; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[sync_stages-1];

    // A channel flips on the tick that completes stable_time consecutive mismatching ticks.
    always_comb begin
        accept = '0;
        for (int i = 0; i < input_count; i++) begin
            accept[i] = (s[i] != switch_outputs[i]) && tick &&
                        (db_cnt[i] == DW'(stable_time - 1));
        end
        out_next = switch_outputs ^ accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < input_count; i++) db_cnt[i] <= '0;
            switch_outputs <= '0;
            rise_pulse     <= '0;
            fall_pulse     <= '0;
        end else begin
            for (int i = 0; i < input_count; i++) begin
                if (s[i] == switch_outputs[i] || accept[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
            switch_outputs <= out_next;
            rise_pulse     <= accept & out_next;
            fall_pulse     <= accept & ~out_next;
        end
    end

    assign any_event = |(rise_pulse | fall_pulse);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LW = $clog2(long_press_time + 1);

    logic [LW-1:0] lp_cnt [input_count];

    // Clearing on out_next drops long_held in the same cycle the fall pulse appears;
    // counting on the registered level starts the count on the first tick after the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < input_count; i++) lp_cnt[i] <= '0;
            long_press <= '0;
            long_held  <= '0;
        end else begin
            for (int i = 0; i < input_count; i++) begin
                long_press[i] <= 1'b0;
                if (!out_next[i]) begin
                    lp_cnt[i]    <= '0;
                    long_held[i] <= 1'b0;
                end else if (switch_outputs[i] && tick &&
                             lp_cnt[i] != LW'(long_press_time)) begin
                    lp_cnt[i] <= lp_cnt[i] + LW'(1);
                    if (lp_cnt[i] == LW'(long_press_time - 1)) begin
                        long_press[i] <= 1'b1;
                        long_held[i]  <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign long_press = '0;
    assign long_held  = '0;
`endif

endmodule

// File: tb/tb_input_debounce_events.sv
// Directed bench for input_debounce_events: expected events are queued with their allowed
// cycle windows when inputs are driven, and matched against pulses seen on the falling edge.
module tb_input_debounce_events;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] switch_inputs;
    logic [N-1:0] switch_outputs, rise_pulse, fall_pulse, long_press, long_held;
    logic         any_event;

    input_debounce_events #(
        .clk_freq(10_000), .stable_time(3), .input_count(N),
        .sync_stages(2), .long_press_time(20)
    ) dut (
        .clk(clk), .reset(reset), .switch_inputs(switch_inputs),
        .switch_outputs(switch_outputs), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .long_press(long_press), .long_held(long_held), .any_event(any_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 rise, 1 fall, 2 long press (window relative to last ch0 rise)
        logic [3:0] mask;
        int         lo;
        int         hi;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  rise_cyc0 = 0;
    int  vectors = 0;
    int  errs = 0;
    int  now;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic LP_ON = 1'b1;
`else
    localparam logic LP_ON = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] mask, input int lo, input int hi);
        ev_t e;
        e.kind = kind; e.mask = mask; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"},  switch_outputs, 0);
        chk({tag, "_rise"}, rise_pulse, 0);
        chk({tag, "_fall"}, fall_pulse, 0);
        chk({tag, "_lp"},   long_press, 0);
        chk({tag, "_held"}, long_held, 0);
        chk({tag, "_any"},  any_event, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [3:0] obs;
        logic       exp_evt;
        logic       ok;
        int         lo, hi;
        ev_t        e;
        exp_evt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = (k == 0) ? rise_pulse : (k == 1) ? fall_pulse : long_press;
            if (obs != 0) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_kind%0d_cyc%0d", k, cyc), obs, 0);
                end else begin
                    e  = sb.pop_front();
                    lo = (e.kind == 2) ? rise_cyc0 + e.lo : e.lo;
                    hi = (e.kind == 2) ? rise_cyc0 + e.hi : e.hi;
                    ok = (e.kind == k) && (e.mask == obs) && (cyc >= lo) && (cyc <= hi);
                    vectors++;
                    assert (ok) else begin
                        errs++;
                        $error("FAIL event observed kind=%0d mask=%h cyc=%0d expected kind=%0d mask=%h cyc=%0d..%0d",
                               k, obs, cyc, e.kind, e.mask, lo, hi);
                    end
                    if (ok && k < 2) exp_evt = 1'b1;
                end
                if (k == 0 && obs[0]) rise_cyc0 = cyc;
                if (k == 1) chk("held_at_fall", long_held & obs, 0);
            end
        end
        chk("any_event", any_event, exp_evt);
    end

    initial begin
        reset = 1'b1;
        switch_inputs = 4'hF;

        // Reset with inputs high, then release
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk_all_zero("in_reset");
        end
        reset = 1'b0;
        now = cyc;
        expect_ev(0, 4'hF, now + 21, now + 32);
        step(40);
        chk("after_reset_out", switch_outputs, 4'hF);
        switch_inputs = 4'h0;
        now = cyc;
        expect_ev(1, 4'hF, now + 23, now + 32);
        step(40);
        chk("all_low_out", switch_outputs, 4'h0);

        // Glitch rejection on channel 0
        switch_inputs = 4'h1;
        step(1);
        switch_inputs = 4'h0;
        step(20);
        switch_inputs = 4'h1;
        step(15);
        switch_inputs = 4'h0;
        step(50);
        chk("glitch_out", switch_outputs, 4'h0);

        // Clean press / release on channel 1
        switch_inputs = 4'h2;
        now = cyc;
        expect_ev(0, 4'h2, now + 23, now + 32);
        step(100);
        chk("press1_out", switch_outputs, 4'h2);
        switch_inputs = 4'h0;
        now = cyc;
        expect_ev(1, 4'h2, now + 23, now + 32);
        step(40);
        chk("release1_out", switch_outputs, 4'h0);

        // Simultaneous channels 2 and 3
        switch_inputs = 4'hC;
        now = cyc;
        expect_ev(0, 4'hC, now + 23, now + 32);
        step(40);
        chk("simul_out", switch_outputs, 4'hC);
        switch_inputs = 4'h0;
        now = cyc;
        expect_ev(1, 4'hC, now + 23, now + 32);
        step(40);
        chk("simul_release_out", switch_outputs, 4'h0);

        // Long press on channel 0
        switch_inputs = 4'h1;
        now = cyc;
        expect_ev(0, 4'h1, now + 23, now + 32);
        if (LP_ON) expect_ev(2, 4'h1, 200, 200);
        step(300);
        chk("long_held_high", long_held, {3'b000, LP_ON});
        switch_inputs = 4'h0;
        now = cyc;
        expect_ev(1, 4'h1, now + 23, now + 32);
        step(22);
        chk("long_held_before_fall", long_held, {3'b000, LP_ON});
        step(20);
        chk("long_held_after_fall", long_held, 0);
        chk("long_release_out", switch_outputs, 4'h0);

        // Reset during a pending window on channel 1
        switch_inputs = 4'h2;
        step(15);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_all_zero("mid_reset");
        end
        reset = 1'b0;
        now = cyc;
        expect_ev(0, 4'h2, now + 21, now + 32);
        step(20);
        chk("post_reset_pending_out", switch_outputs, 4'h0);
        step(20);
        chk("post_reset_out", switch_outputs, 4'h2);
        switch_inputs = 4'h0;
        now = cyc;
        expect_ev(1, 4'h2, now + 23, now + 32);
        step(40);
        chk("final_out", switch_outputs, 4'h0);

        chk("scoreboard_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
